// File: rtl/dest_ip_filter_reg_bridge.sv
// Host register bridge to the destination-IP filter table port: turns 32-bit
// register accesses into table req/ack handshakes with timeout and sticky status.
module dest_ip_filter_reg_bridge #(
   parameter int LUT_DEPTH      = 32,
   parameter int LUT_DEPTH_BITS = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reg_req,
   input  logic                      reg_rd_wr_L,
   input  logic [1:0]                reg_addr,
   input  logic [31:0]               reg_wr_data,
   output logic                      reg_ack,
   output logic [31:0]               reg_rd_data,
   output logic [LUT_DEPTH_BITS-1:0] table_rd_addr,
   output logic                      table_rd_req,
   input  logic [31:0]               table_rd_ip,
   input  logic                      table_rd_ack,
   output logic [LUT_DEPTH_BITS-1:0] table_wr_addr,
   output logic                      table_wr_req,
   output logic [31:0]               table_wr_ip,
   input  logic                      table_wr_ack
);

   localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] DEPTH = 32'(LUT_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_WAIT = 2'd1;
   localparam logic [1:0] S_WR_WAIT = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [1:0] A_ENTRY  = 2'd0;
   localparam logic [1:0] A_RD     = 2'd1;
   localparam logic [1:0] A_WR     = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic [1:0]                state;
   logic [CNT_BITS-1:0]       cnt;
   logic [31:0]               entry_ip;
   logic [LUT_DEPTH_BITS-1:0] rd_addr;
   logic [LUT_DEPTH_BITS-1:0] wr_addr;
   logic                      timeout;
   logic                      range_err;
   logic                      busy;
   logic                      tbl_write;
   logic                      in_range;
   logic [31:0]               read_data;

   assign busy          = (state == S_RD_WAIT) || (state == S_WR_WAIT);
   assign tbl_write     = !reg_rd_wr_L && ((reg_addr == A_RD) || (reg_addr == A_WR));
   assign in_range      = reg_wr_data < DEPTH;
   assign table_rd_addr = rd_addr;
   assign table_wr_addr = wr_addr;
   assign table_wr_ip   = entry_ip;

   always_comb begin
      read_data = '0;
      case (reg_addr)
         A_ENTRY: read_data = entry_ip;
         A_RD:    read_data = 32'(rd_addr);
         A_WR:    read_data = 32'(wr_addr);
         default: read_data = {29'b0, range_err, timeout, busy};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         entry_ip     <= '0;
         rd_addr      <= '0;
         wr_addr      <= '0;
         timeout      <= 1'b0;
         range_err    <= 1'b0;
         reg_ack      <= 1'b0;
         reg_rd_data  <= '0;
         table_rd_req <= 1'b0;
         table_wr_req <= 1'b0;
      end else begin
         reg_ack     <= 1'b0;
         reg_rd_data <= '0;
         case (state)
            S_IDLE: begin
               if (reg_req && tbl_write) begin
                  if (reg_addr == A_RD) rd_addr <= reg_wr_data[LUT_DEPTH_BITS-1:0];
                  else                  wr_addr <= reg_wr_data[LUT_DEPTH_BITS-1:0];
                  cnt <= '0;
                  if (!in_range) begin
                     range_err <= 1'b1;
                     reg_ack   <= 1'b1;
                     state     <= S_RESP;
                  end else if (reg_addr == A_RD) begin
                     table_rd_req <= 1'b1;
                     state        <= S_RD_WAIT;
                  end else begin
                     table_wr_req <= 1'b1;
                     state        <= S_WR_WAIT;
                  end
               end else if (reg_req) begin
                  reg_ack <= 1'b1;
                  state   <= S_RESP;
                  if (reg_rd_wr_L) begin
                     reg_rd_data <= read_data;
                  end else if (reg_addr == A_ENTRY) begin
                     entry_ip <= reg_wr_data;
                  end else begin
                     if (reg_wr_data[1]) timeout   <= 1'b0;
                     if (reg_wr_data[2]) range_err <= 1'b0;
                  end
               end
            end
            // Ack is tested before the limit so a same-cycle ack completes normally.
            S_RD_WAIT: begin
               if (table_rd_ack) begin
                  table_rd_req <= 1'b0;
                  reg_ack      <= 1'b1;
                  entry_ip     <= table_rd_ip;
                  state        <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  table_rd_req <= 1'b0;
                  timeout      <= 1'b1;
                  reg_ack      <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WR_WAIT: begin
               if (table_wr_ack) begin
                  table_wr_req <= 1'b0;
                  reg_ack      <= 1'b1;
                  state        <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  table_wr_req <= 1'b0;
                  timeout      <= 1'b1;
                  reg_ack      <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dest_ip_filter_reg_bridge.sv
// Self-checking bench for dest_ip_filter_reg_bridge: directed vectors, a reset
// corner sequence, and random transactions against a behavioural register model.
module tb_dest_ip_filter_reg_bridge;

   localparam int DEPTH = 32;
   localparam int ABITS = 5;
   localparam int TMO   = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             reg_req;
   logic             reg_rd_wr_L;
   logic [1:0]       reg_addr;
   logic [31:0]      reg_wr_data;
   logic             reg_ack;
   logic [31:0]      reg_rd_data;
   logic [ABITS-1:0] table_rd_addr;
   logic             table_rd_req;
   logic [31:0]      table_rd_ip;
   logic             table_rd_ack;
   logic [ABITS-1:0] table_wr_addr;
   logic             table_wr_req;
   logic [31:0]      table_wr_ip;
   logic             table_wr_ack;

   logic             resp_rd_ack = 1'b0;
   logic             resp_wr_ack = 1'b0;
   logic             stray_ack = 1'b0;

   assign table_rd_ack = resp_rd_ack | stray_ack;
   assign table_wr_ack = resp_wr_ack | stray_ack;

   dest_ip_filter_reg_bridge #(
      .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(ABITS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
      .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack),
      .reg_rd_data(reg_rd_data), .table_rd_addr(table_rd_addr),
      .table_rd_req(table_rd_req), .table_rd_ip(table_rd_ip),
      .table_rd_ack(table_rd_ack), .table_wr_addr(table_wr_addr),
      .table_wr_req(table_wr_req), .table_wr_ip(table_wr_ip),
      .table_wr_ack(table_wr_ack)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Table responder: acks after ack_delay request cycles (0 = never), and
   // records each request episode's length, address and write IP.
   int          ack_delay = 0;
   logic [31:0] rsp_ip = '0;
   int          cur_len = 0;
   int          last_len = 0;
   int          episodes = 0;
   int          unstable = 0;
   logic [31:0] cap_addr = '0;
   logic [31:0] cap_ip = '0;

   always @(negedge clk) begin
      resp_rd_ack = 1'b0;
      resp_wr_ack = 1'b0;
      table_rd_ip = $urandom;
      if (table_rd_req || table_wr_req) begin
         if (cur_len == 0) begin
            cap_addr = table_rd_req ? 32'(table_rd_addr) : 32'(table_wr_addr);
            cap_ip   = table_wr_ip;
         end else if ((table_rd_req ? 32'(table_rd_addr) : 32'(table_wr_addr)) !== cap_addr
                      || (table_wr_req && table_wr_ip !== cap_ip)) begin
            unstable++;
         end
         cur_len++;
         if (cur_len == ack_delay) begin
            if (table_rd_req) begin
               resp_rd_ack = 1'b1;
               table_rd_ip = rsp_ip;
            end else begin
               resp_wr_ack = 1'b1;
            end
         end
      end else if (cur_len > 0) begin
         last_len = cur_len;
         cur_len  = 0;
         episodes++;
      end
   end

   // Behavioural register model
   logic [31:0] m_entry, m_rd, m_wr;
   logic        m_tmo, m_range;

   task automatic model_reset();
      m_entry = '0; m_rd = '0; m_wr = '0; m_tmo = 1'b0; m_range = 1'b0;
   endtask

   task automatic model_txn(input logic rw, input logic [1:0] a, input logic [31:0] d,
                            input int delay, input logic [31:0] ip,
                            output logic [31:0] exp_rd, output int exp_lat, output int exp_len,
                            output logic [31:0] exp_taddr, output logic [31:0] exp_tip);
      logic [31:0] idx;
      exp_rd = '0; exp_lat = 1; exp_len = 0; exp_taddr = '0; exp_tip = '0;
      if (rw) begin
         case (a)
            2'd0: exp_rd = m_entry;
            2'd1: exp_rd = m_rd;
            2'd2: exp_rd = m_wr;
            default: exp_rd = {29'b0, m_range, m_tmo, 1'b0};
         endcase
      end else if (a == 2'd0) begin
         m_entry = d;
      end else if (a == 2'd3) begin
         if (d[1]) m_tmo = 1'b0;
         if (d[2]) m_range = 1'b0;
      end else begin
         idx = d % DEPTH;
         if (a == 2'd1) m_rd = idx; else m_wr = idx;
         if (d >= DEPTH) begin
            m_range = 1'b1;
         end else begin
            exp_taddr = idx;
            exp_tip   = m_entry;
            if (delay >= 1 && delay <= TMO) begin
               exp_len = delay;
               exp_lat = delay + 1;
               if (a == 2'd1) m_entry = ip;
            end else begin
               exp_len = TMO;
               exp_lat = TMO + 1;
               m_tmo   = 1'b1;
            end
         end
      end
   endtask

   task automatic do_txn(input logic rw, input logic [1:0] a, input logic [31:0] d,
                         input int delay, input logic [31:0] ip,
                         output logic [31:0] rdata, output int lat, output int len);
      int  base;
      bit  got;
      base      = episodes;
      ack_delay = delay;
      rsp_ip    = ip;
      @(negedge clk);
      reg_req = 1'b1; reg_rd_wr_L = rw; reg_addr = a; reg_wr_data = d;
      got = 0; lat = 0; rdata = 'x;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         if (reg_ack) begin
            got   = 1;
            rdata = reg_rd_data;
         end
      end
      reg_req = 1'b0;
      if (!got) check("ack_wait_expired", 32'(lat), 32'd0);
      @(negedge clk);
      check("ack_single_pulse", {31'b0, reg_ack}, 32'd0);
      check("rd_data_idle_zero", reg_rd_data, 32'd0);
      check("req_episodes", 32'(episodes - base), (episodes - base > 0 || delay < 0) ? 32'd1 : 32'd0);
      len = (episodes - base > 0) ? last_len : 0;
   endtask

   task automatic run_one(input logic rw, input logic [1:0] a, input logic [31:0] d,
                          input int delay, input logic [31:0] ip, input bit use_vec,
                          input logic [31:0] v_rd, input int v_lat, input int v_len);
      logic [31:0] e_rd, e_ta, e_tip, rdata;
      int          e_lat, e_len, lat, len;
      model_txn(rw, a, d, delay, ip, e_rd, e_lat, e_len, e_ta, e_tip);
      if (use_vec) begin
         e_rd = v_rd; e_lat = v_lat; e_len = v_len;
      end
      do_txn(rw, a, d, delay, ip, rdata, lat, len);
      check("reg_rd_data", rdata, e_rd);
      check("ack_latency", 32'(lat), 32'(e_lat));
      check("req_length", 32'(len), 32'(e_len));
      if (len > 0) begin
         check("table_addr", cap_addr, e_ta);
         if (a == 2'd2) check("table_wr_ip", cap_ip, e_tip);
      end
   endtask

   typedef struct {
      logic        rw;
      logic [1:0]  a;
      logic [31:0] d;
      int          delay;
      logic [31:0] ip;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          exp_len;
   } vec_t;

   vec_t vq[$];

   initial begin
      vq.push_back('{1'b0, 2'd0, 32'hC0A80101, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd2, 32'd5, 3, 32'h0, 32'h0, 4, 3});
      vq.push_back('{1'b1, 2'd3, 32'h0, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd1, 32'd7, 2, 32'h0A000001, 32'h0, 3, 2});
      vq.push_back('{1'b1, 2'd0, 32'h0, 0, 32'h0, 32'h0A000001, 1, 0});
      vq.push_back('{1'b1, 2'd1, 32'h0, 0, 32'h0, 32'd7, 1, 0});
      vq.push_back('{1'b0, 2'd2, 32'd9, 0, 32'h0, 32'h0, TMO + 1, TMO});
      vq.push_back('{1'b1, 2'd3, 32'h0, 0, 32'h0, 32'h2, 1, 0});
      vq.push_back('{1'b0, 2'd3, 32'h2, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b1, 2'd3, 32'h0, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd1, 32'd32, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b1, 2'd3, 32'h0, 0, 32'h0, 32'h4, 1, 0});
      vq.push_back('{1'b1, 2'd1, 32'h0, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd3, 32'h4, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd1, 32'd3, TMO, 32'h12345678, 32'h0, TMO + 1, TMO});
      vq.push_back('{1'b1, 2'd3, 32'h0, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b1, 2'd0, 32'h0, 0, 32'h0, 32'h12345678, 1, 0});
      vq.push_back('{1'b1, 2'd2, 32'h0, 0, 32'h0, 32'd9, 1, 0});
      vq.push_back('{1'b0, 2'd0, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 1, 0});
      vq.push_back('{1'b0, 2'd2, 32'd31, 1, 32'h0, 32'h0, 2, 1});

      reset = 1'b1; reg_req = 1'b0; reg_rd_wr_L = 1'b1; reg_addr = '0; reg_wr_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_wr_ip", table_wr_ip, 32'd0);
      check("reset_ctrl", {12'b0, reg_ack, table_rd_req, table_wr_req,
                           2'b0, table_rd_addr, 6'b0, table_wr_addr}, 32'd0);
      check("reset_rd_data", reg_rd_data, 32'd0);

      foreach (vq[i])
         run_one(vq[i].rw, vq[i].a, vq[i].d, vq[i].delay, vq[i].ip, 1'b1,
                 vq[i].exp_rd, vq[i].exp_lat, vq[i].exp_len);

      // Reset during RD_WAIT, then a late ack that must be ignored
      begin
         bit seen;
         ack_delay = 0;
         @(negedge clk);
         reg_req = 1'b1; reg_rd_wr_L = 1'b0; reg_addr = 2'd1; reg_wr_data = 32'd4;
         @(negedge clk);
         reg_req = 1'b0;
         repeat (3) @(negedge clk);
         check("rd_req_mid_txn", {31'b0, table_rd_req}, 32'd1);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("reset_mid_ctrl", {12'b0, reg_ack, table_rd_req, table_wr_req,
                                  2'b0, table_rd_addr, 6'b0, table_wr_addr}, 32'd0);
         check("reset_mid_wr_ip", table_wr_ip, 32'd0);
         stray_ack = 1'b1;
         @(negedge clk);
         stray_ack = 1'b0;
         seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (reg_ack || table_rd_req || table_wr_req) seen = 1;
         end
         check("stray_ack_ignored", {31'b0, seen}, 32'd0);
         model_reset();
         run_one(1'b1, 2'd0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1, 0);
         run_one(1'b1, 2'd3, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1, 0);
         run_one(1'b1, 2'd1, 32'h0, 0, 32'h0, 1'b1, 32'h0, 1, 0);
      end

      for (int n = 0; n < 60; n++) begin
         int          op, dl;
         logic [31:0] d;
         op = $urandom_range(0, 7);
         dl = $urandom_range(0, 9);
         dl = (dl == 0) ? 0 : (dl == 1) ? TMO : int'($urandom_range(1, 8));
         d  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
         case (op)
            0: run_one(1'b0, 2'd0, $urandom, 0, 32'h0, 1'b0, 0, 0, 0);
            1: run_one(1'b1, 2'd0, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0);
            2: run_one(1'b0, 2'd1, d, dl, $urandom, 1'b0, 0, 0, 0);
            3: run_one(1'b0, 2'd2, d, dl, 32'h0, 1'b0, 0, 0, 0);
            4: run_one(1'b1, 2'd1, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0);
            5: run_one(1'b1, 2'd2, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0);
            6: run_one(1'b1, 2'd3, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0);
            default: run_one(1'b0, 2'd3, 32'($urandom_range(0, 7)), 0, 32'h0, 1'b0, 0, 0, 0);
         endcase
      end

      check("addr_ip_stable", 32'(unstable), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
